// File: rtl/down_counter_bo_pkg.sv
// down_counter_bo_pkg: shared state encodings and default sizing for the down counter.
// Holds what a defs header would carry; the DOWN_CNT_RELOAD_EN guard lives in the top.
package down_counter_bo_pkg;
    localparam int DEF_WIDTH   = 4;
    localparam int DEF_MODULUS = 16;
    typedef enum logic {
        ST_EMPTY  = 1'b0,
        ST_LOADED = 1'b1
    } state_e;
endpackage

// File: rtl/down_counter_bo.sv
// down_counter_bo: presettable modulo-N down counter with combinational borrow out.
// Build option DOWN_CNT_RELOAD_EN: wrap from zero reloads the last preset once one is held.
module down_counter_bo
    import down_counter_bo_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MODULUS = DEF_MODULUS
) (
    input  logic             clk,
    input  logic             mr,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             bo
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_q, q_d, preset, wrap;

    // Out-of-range presets saturate so q never leaves 0..MODULUS-1.
    assign preset = (d > MAX) ? MAX : d;

`ifdef DOWN_CNT_RELOAD_EN
    state_e           state_q;
    logic [WIDTH-1:0] reload_q;

    assign wrap = (state_q == ST_LOADED) ? reload_q : MAX;

    always_ff @(posedge clk or negedge mr) begin
        if (!mr) begin
            state_q  <= ST_EMPTY;
            reload_q <= '0;
        end else if (!load) begin
            state_q  <= ST_LOADED;
            reload_q <= preset;
        end
    end
`else
    assign wrap = MAX;
`endif

    always_comb q_d = !load ? preset : en ? ((q_q == '0) ? wrap : q_q - WIDTH'(1)) : q_q;

    always_ff @(posedge clk or negedge mr) begin
        if (!mr) q_q <= '0;
        else     q_q <= q_d;
    end

    assign q  = q_q;
    assign bo = en & (q_q == '0);
endmodule

// File: tb/tb_down_counter_bo.sv
// tb_down_counter_bo: directed vector table plus hand sequences for reset and modulus corners.
module tb_down_counter_bo;
`ifdef DOWN_CNT_RELOAD_EN
    localparam bit RL = 1'b1;
`else
    localparam bit RL = 1'b0;
`endif

    logic       clk = 1'b0, clk_run = 1'b0;
    logic       mr, load, en;
    logic [3:0] d, q16, q10;
    logic       bo16, bo10;
    int         n_chk = 0, n_pass = 0;

    down_counter_bo #(.WIDTH(4), .MODULUS(16)) u16 (
        .clk(clk), .mr(mr), .load(load), .en(en), .d(d), .q(q16), .bo(bo16));
    down_counter_bo #(.WIDTH(4), .MODULUS(10)) u10 (
        .clk(clk), .mr(mr), .load(load), .en(en), .d(d), .q(q10), .bo(bo10));

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    typedef struct {
        logic       ld;
        logic       e;
        logic [3:0] dv;
        logic [3:0] eq;
        logic       eb;
    } vec_t;

    vec_t tv[16];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step(input logic ld, input logic e, input logic [3:0] dv);
        @(negedge clk);
        load = ld;
        en   = e;
        d    = dv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tv[0]  = '{1'b0, 1'b0, 4'd5, 4'd5, 1'b0};
        tv[1]  = '{1'b1, 1'b1, 4'd0, 4'd4, 1'b0};
        tv[2]  = '{1'b1, 1'b1, 4'd0, 4'd3, 1'b0};
        tv[3]  = '{1'b1, 1'b1, 4'd0, 4'd2, 1'b0};
        tv[4]  = '{1'b1, 1'b1, 4'd0, 4'd1, 1'b0};
        tv[5]  = '{1'b1, 1'b1, 4'd0, 4'd0, 1'b1};
        tv[6]  = '{1'b1, 1'b1, 4'd0, RL ? 4'd5 : 4'd15, 1'b0};
        tv[7]  = '{1'b0, 1'b0, 4'd9, 4'd9, 1'b0};
        tv[8]  = '{1'b1, 1'b0, 4'd0, 4'd9, 1'b0};
        tv[9]  = '{1'b1, 1'b0, 4'd0, 4'd9, 1'b0};
        tv[10] = '{1'b1, 1'b0, 4'd0, 4'd9, 1'b0};
        tv[11] = '{1'b0, 1'b1, 4'd3, 4'd3, 1'b0};
        tv[12] = '{1'b1, 1'b1, 4'd0, 4'd2, 1'b0};
        tv[13] = '{1'b1, 1'b1, 4'd0, 4'd1, 1'b0};
        tv[14] = '{1'b1, 1'b1, 4'd0, 4'd0, 1'b1};
        tv[15] = '{1'b1, 1'b1, 4'd0, RL ? 4'd3 : 4'd15, 1'b0};

        // Reset with the clock idle: outputs settle without any edge.
        mr = 1'b0; load = 1'b1; en = 1'b0; d = 4'd0;
        #5 en = 1'b1;
        #1;
        chk("reset_q", q16, 0);
        chk("reset_bo", bo16, 1);
        en = 1'b0;
        mr = 1'b1;
        #1;
        chk("release_q", q16, 0);
        clk_run = 1'b1;
        step(1'b1, 1'b0, 4'd0);
        chk("first_edge_q", q16, 0);

        for (int i = 0; i < 16; i++) begin
            step(tv[i].ld, tv[i].e, tv[i].dv);
            chk($sformatf("vec%0d_q", i), q16, tv[i].eq);
            chk($sformatf("vec%0d_bo", i), bo16, tv[i].eb);
        end

        // MODULUS=10: saturated preset, then count down and wrap.
        step(1'b0, 1'b0, 4'd12);
        chk("m10_sat_q", q10, 9);
        for (int i = 8; i >= 0; i--) begin
            step(1'b1, 1'b1, 4'd0);
            chk($sformatf("m10_cnt%0d_q", i), q10, i);
        end
        chk("m10_bo_at_zero", bo10, 1);
        step(1'b1, 1'b1, 4'd0);
        chk("m10_wrap_q", q10, 9);

        // Async reset mid-count clears the preset so the next wrap goes to MODULUS-1.
        step(1'b0, 1'b0, 4'd8);
        step(1'b1, 1'b1, 4'd0);
        step(1'b1, 1'b1, 4'd0);
        chk("pre_mr_q", q16, 6);
        @(negedge clk);
        mr = 1'b0;
        #1;
        chk("mid_mr_q", q16, 0);
        chk("mid_mr_bo", bo16, 1);
        #1 mr = 1'b1;
        @(posedge clk);
        #1;
        chk("post_mr_wrap_q", q16, 15);
        chk("post_mr_wrap_bo", bo16, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
